// File: rtl/decode_stage.sv
// RV32I/RV32E decode stage: one registered output slot with valid/ready handshake,
// operand read with write-back bypass, and a one-bubble load-use interlock.
module decode_stage #(
  parameter int XLEN      = 32,
  parameter int RF_ADDR_W = 5,
  parameter bit BYPASS_EN = 1'b1,
  parameter bit HAZARD_EN = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [XLEN-1:0]      in_pc,
  input  logic [31:0]          in_inst,
  output logic [RF_ADDR_W-1:0] rs1_addr,
  output logic [RF_ADDR_W-1:0] rs2_addr,
  input  logic [XLEN-1:0]      rs1_val,
  input  logic [XLEN-1:0]      rs2_val,
  input  logic                 wb_en,
  input  logic [RF_ADDR_W-1:0] wb_addr,
  input  logic [XLEN-1:0]      wb_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [XLEN-1:0]      out_pc,
  output logic [RF_ADDR_W-1:0] out_rd,
  output logic                 out_rd_we,
  output logic [XLEN-1:0]      out_imm,
  output logic [XLEN-1:0]      out_rs1_val,
  output logic [XLEN-1:0]      out_rs2_val,
  output logic [3:0]           out_alu_op,
  output logic [1:0]           out_op1_sel,
  output logic [1:0]           out_op2_sel,
  output logic [2:0]           out_fu,
  output logic [2:0]           out_func3,
  output logic                 out_illegal
);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_SLL   = 4'd2;
  localparam logic [3:0] ALU_SLT   = 4'd3;
  localparam logic [3:0] ALU_SLTU  = 4'd4;
  localparam logic [3:0] ALU_XOR   = 4'd5;
  localparam logic [3:0] ALU_SRL   = 4'd6;
  localparam logic [3:0] ALU_SRA   = 4'd7;
  localparam logic [3:0] ALU_OR    = 4'd8;
  localparam logic [3:0] ALU_AND   = 4'd9;
  localparam logic [3:0] ALU_PASSB = 4'd10;

  localparam logic [1:0] OP1_RS1  = 2'd0;
  localparam logic [1:0] OP1_PC   = 2'd1;
  localparam logic [1:0] OP1_ZERO = 2'd2;
  localparam logic [1:0] OP2_RS2  = 2'd0;
  localparam logic [1:0] OP2_IMM  = 2'd1;
  localparam logic [1:0] OP2_FOUR = 2'd2;

  localparam logic [2:0] FU_ALU    = 3'd0;
  localparam logic [2:0] FU_BRANCH = 3'd1;
  localparam logic [2:0] FU_JUMP   = 3'd2;
  localparam logic [2:0] FU_LOAD   = 3'd3;
  localparam logic [2:0] FU_STORE  = 3'd4;
  localparam logic [2:0] FU_SYSTEM = 3'd5;

  typedef struct packed {
    logic [XLEN-1:0]      pc;
    logic [RF_ADDR_W-1:0] rd;
    logic                 rd_we;
    logic [XLEN-1:0]      imm;
    logic [XLEN-1:0]      rs1_val;
    logic [XLEN-1:0]      rs2_val;
    logic [3:0]           alu_op;
    logic [1:0]           op1_sel;
    logic [1:0]           op2_sel;
    logic [2:0]           fu;
    logic [2:0]           func3;
    logic                 illegal;
  } bundle_t;

  function automatic logic [3:0] alu_sel(input logic [2:0] f, input logic alt);
    case (f)
      3'b000:  alu_sel = alt ? ALU_SUB : ALU_ADD;
      3'b001:  alu_sel = ALU_SLL;
      3'b010:  alu_sel = ALU_SLT;
      3'b011:  alu_sel = ALU_SLTU;
      3'b100:  alu_sel = ALU_XOR;
      3'b101:  alu_sel = alt ? ALU_SRA : ALU_SRL;
      3'b110:  alu_sel = ALU_OR;
      default: alu_sel = ALU_AND;
    endcase
  endfunction

  logic [6:0]           opc;
  logic [2:0]           f3;
  logic [6:0]           f7;
  logic [RF_ADDR_W-1:0] rs1_idx, rs2_idx, rd_idx;
  logic [31:0]          imm_i, imm_s, imm_b, imm_u, imm_j;
  logic                 f7_bad, is_shift;
  logic                 uses_rs1, uses_rs2, has_rd, illegal;
  logic [XLEN-1:0]      op1_val, op2_val;
  logic                 stall_lu, accept;
  bundle_t              dec, bun_d, bun_q;
  logic                 out_valid_d, out_valid_q;

  assign opc     = in_inst[6:0];
  assign f3      = in_inst[14:12];
  assign f7      = in_inst[31:25];
  assign rs1_idx = in_inst[15 +: RF_ADDR_W];
  assign rs2_idx = in_inst[20 +: RF_ADDR_W];
  assign rd_idx  = in_inst[7 +: RF_ADDR_W];
  assign rs1_addr = rs1_idx;
  assign rs2_addr = rs2_idx;

  assign imm_i = {{20{in_inst[31]}}, in_inst[31:20]};
  assign imm_s = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
  assign imm_b = {{20{in_inst[31]}}, in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
  assign imm_u = {in_inst[31:12], 12'b0};
  assign imm_j = {{12{in_inst[31]}}, in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};

  // funct7 must be 0, or 0x20 only for the ADD/SUB and SRL/SRA pairs
  assign f7_bad   = !((f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101)));
  assign is_shift = (f3 == 3'b001) || (f3 == 3'b101);

  always_comb begin
    op1_val = rs1_val;
    if (rs1_idx == '0)
      op1_val = '0;
    else if (BYPASS_EN && wb_en && wb_addr == rs1_idx)
      op1_val = wb_data;
  end

  always_comb begin
    op2_val = rs2_val;
    if (rs2_idx == '0)
      op2_val = '0;
    else if (BYPASS_EN && wb_en && wb_addr == rs2_idx)
      op2_val = wb_data;
  end

  always_comb begin
    dec         = '0;
    dec.pc      = in_pc;
    dec.rd      = rd_idx;
    dec.func3   = f3;
    dec.rs1_val = op1_val;
    dec.rs2_val = op2_val;
    dec.alu_op  = ALU_ADD;
    dec.op1_sel = OP1_RS1;
    dec.op2_sel = OP2_IMM;
    dec.fu      = FU_ALU;
    dec.imm     = imm_i;
    uses_rs1    = 1'b1;
    uses_rs2    = 1'b0;
    has_rd      = 1'b0;
    illegal     = (in_inst[1:0] != 2'b11);
    case (opc)
      OPC_LUI: begin
        uses_rs1    = 1'b0;
        has_rd      = 1'b1;
        dec.op1_sel = OP1_ZERO;
        dec.alu_op  = ALU_PASSB;
        dec.imm     = imm_u;
      end
      OPC_AUIPC: begin
        uses_rs1    = 1'b0;
        has_rd      = 1'b1;
        dec.op1_sel = OP1_PC;
        dec.imm     = imm_u;
      end
      OPC_JAL: begin
        uses_rs1    = 1'b0;
        has_rd      = 1'b1;
        dec.op1_sel = OP1_PC;
        dec.op2_sel = OP2_FOUR;
        dec.fu      = FU_JUMP;
        dec.imm     = imm_j;
      end
      OPC_JALR: begin
        has_rd      = 1'b1;
        dec.op1_sel = OP1_PC;
        dec.op2_sel = OP2_FOUR;
        dec.fu      = FU_JUMP;
        illegal     = illegal | (f3 != 3'b000);
      end
      OPC_BRANCH: begin
        uses_rs2    = 1'b1;
        dec.op2_sel = OP2_RS2;
        dec.alu_op  = ALU_SUB;
        dec.fu      = FU_BRANCH;
        dec.imm     = imm_b;
        illegal     = illegal | (f3 == 3'b010) | (f3 == 3'b011);
      end
      OPC_LOAD: begin
        has_rd  = 1'b1;
        dec.fu  = FU_LOAD;
        illegal = illegal | (f3 == 3'b011) | (f3 == 3'b110) | (f3 == 3'b111);
      end
      OPC_STORE: begin
        uses_rs2 = 1'b1;
        dec.fu   = FU_STORE;
        dec.imm  = imm_s;
        illegal  = illegal | (f3 >= 3'b011);
      end
      OPC_OPIMM: begin
        has_rd     = 1'b1;
        dec.alu_op = alu_sel(f3, (f3 == 3'b101) && in_inst[30]);
        if (is_shift) begin
          dec.imm = {27'b0, in_inst[24:20]};
          illegal = illegal | f7_bad;
        end
      end
      OPC_OP: begin
        has_rd      = 1'b1;
        uses_rs2    = 1'b1;
        dec.op2_sel = OP2_RS2;
        dec.alu_op  = alu_sel(f3, in_inst[30]);
        dec.imm     = '0;
        illegal     = illegal | f7_bad;
      end
      OPC_FENCE, OPC_SYSTEM: dec.fu = FU_SYSTEM;
      default: illegal = 1'b1;
    endcase
    // RV32E: upper-bank register indices do not exist
    if (RF_ADDR_W < 5)
      illegal = illegal | (uses_rs1 & in_inst[19]) | (uses_rs2 & in_inst[24]) | (has_rd & in_inst[11]);
    dec.illegal = illegal;
    dec.rd_we   = has_rd && (in_inst[11:7] != 5'd0) && !illegal;
    if (illegal)
      dec.fu = FU_SYSTEM;
  end

  assign stall_lu = HAZARD_EN && out_valid_q && (bun_q.fu == FU_LOAD) && (bun_q.rd != '0) && in_valid &&
                    ((uses_rs1 && rs1_idx == bun_q.rd) || (uses_rs2 && rs2_idx == bun_q.rd));
  assign in_ready = (!out_valid_q || out_ready) && !stall_lu && !flush;
  assign accept   = in_valid && in_ready;

  always_comb begin
    out_valid_d = out_valid_q;
    bun_d       = bun_q;
    if (flush)
      out_valid_d = 1'b0;
    else if (accept) begin
      out_valid_d = 1'b1;
      bun_d       = dec;
    end else if (out_ready)
      out_valid_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      bun_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      bun_q       <= bun_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_pc      = bun_q.pc;
  assign out_rd      = bun_q.rd;
  assign out_rd_we   = bun_q.rd_we;
  assign out_imm     = bun_q.imm;
  assign out_rs1_val = bun_q.rs1_val;
  assign out_rs2_val = bun_q.rs2_val;
  assign out_alu_op  = bun_q.alu_op;
  assign out_op1_sel = bun_q.op1_sel;
  assign out_op2_sel = bun_q.op2_sel;
  assign out_fu      = bun_q.fu;
  assign out_func3   = bun_q.func3;
  assign out_illegal = bun_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed scenarios plus randomized decode checked
// against an instruction-level reference model.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_pc, in_inst, rs1_val, rs2_val, wb_data;
  logic [4:0]  rs1_addr, rs2_addr, wb_addr, out_rd;
  logic        wb_en, out_rd_we, out_illegal;
  logic [31:0] out_pc, out_imm, out_rs1_val, out_rs2_val;
  logic [3:0]  out_alu_op;
  logic [1:0]  out_op1_sel, out_op2_sel;
  logic [2:0]  out_fu, out_func3;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  decode_stage #(.XLEN(32), .RF_ADDR_W(5), .BYPASS_EN(1'b1), .HAZARD_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_inst(in_inst), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_val(rs1_val), .rs2_val(rs2_val), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_rd(out_rd),
    .out_rd_we(out_rd_we), .out_imm(out_imm), .out_rs1_val(out_rs1_val), .out_rs2_val(out_rs2_val),
    .out_alu_op(out_alu_op), .out_op1_sel(out_op1_sel), .out_op2_sel(out_op2_sel),
    .out_fu(out_fu), .out_func3(out_func3), .out_illegal(out_illegal)
  );

  localparam logic [6:0] LUI = 7'h37, AUIPC = 7'h17, JAL = 7'h6F, JALR = 7'h67, BR = 7'h63;
  localparam logic [6:0] LD = 7'h03, ST = 7'h23, OPI = 7'h13, OP = 7'h33, FEN = 7'h0F, SYS = 7'h73;

  typedef struct {
    logic [31:0] pc, imm, r1, r2;
    logic [4:0]  rd;
    logic        rd_we, ill;
    logic [3:0]  alu;
    logic [1:0]  op1, op2;
    logic [2:0]  fu, f3;
    bit          chk_imm, chk_alu, chk_sel, u1, u2;
  } exp_t;

  function automatic exp_t model(input logic [31:0] i, input logic [31:0] pc, r1v, r2v,
                                 input logic wbe, input logic [4:0] wba, input logic [31:0] wbd);
    exp_t e;
    int f3, f7, alu_tab[8];
    bit ok_f7, wr;
    alu_tab = '{0, 2, 3, 4, 5, 6, 8, 9};
    f3 = int'(i[14:12]);
    f7 = int'(i[31:25]);
    ok_f7 = (f7 == 0) || (f7 == 32 && (f3 == 0 || f3 == 5));
    e.pc = pc; e.rd = i[11:7]; e.f3 = i[14:12];
    e.imm = 32'($signed(i[31:20])); e.alu = 0; e.op1 = 0; e.op2 = 1; e.fu = 0;
    e.chk_imm = 1; e.chk_alu = 1; e.chk_sel = 1; wr = 0;
    e.ill = (i[1:0] != 2'b11);
    e.u1 = !(i[6:0] inside {LUI, AUIPC, JAL});
    e.u2 = (i[6:0] inside {OP, ST, BR});
    case (i[6:0])
      LUI:   begin e.op1 = 2; e.alu = 10; e.imm = {i[31:12], 12'h000}; wr = 1; end
      AUIPC: begin e.op1 = 1; e.imm = {i[31:12], 12'h000}; wr = 1; end
      JAL:   begin e.op1 = 1; e.op2 = 2; e.fu = 2; wr = 1;
                   e.imm = 32'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0})); end
      JALR:  begin e.op1 = 1; e.op2 = 2; e.fu = 2; wr = 1; if (f3 != 0) e.ill = 1; end
      BR:    begin e.op2 = 0; e.alu = 1; e.fu = 1; if (f3 == 2 || f3 == 3) e.ill = 1;
                   e.imm = 32'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0})); end
      LD:    begin e.fu = 3; wr = 1; if (f3 == 3 || f3 >= 6) e.ill = 1; end
      ST:    begin e.fu = 4; e.imm = 32'($signed({i[31:25], i[11:7]})); if (f3 >= 3) e.ill = 1; end
      OPI:   begin
               wr = 1;
               e.alu = 4'(alu_tab[f3]);
               if (f3 == 1 || f3 == 5) begin
                 e.imm = 32'(i[24:20]);
                 if (!ok_f7) e.ill = 1;
                 if (f3 == 5 && f7 == 32) e.alu = 7;
               end
             end
      OP:    begin
               wr = 1; e.op2 = 0; e.chk_imm = 0;
               if (!ok_f7) e.ill = 1;
               e.alu = (f7 == 32) ? ((f3 == 0) ? 4'd1 : 4'd7) : 4'(alu_tab[f3]);
             end
      FEN, SYS: begin e.fu = 5; e.chk_imm = 0; e.chk_alu = 0; e.chk_sel = 0; end
      default: e.ill = 1;
    endcase
    if (e.ill) begin e.fu = 5; e.chk_imm = 0; e.chk_alu = 0; e.chk_sel = 0; end
    e.rd_we = wr && (e.rd != 0) && !e.ill;
    e.r1 = (i[19:15] == 0) ? 32'h0 : (wbe && wba == i[19:15]) ? wbd : r1v;
    e.r2 = (i[24:20] == 0) ? 32'h0 : (wbe && wba == i[24:20]) ? wbd : r2v;
    return e;
  endfunction

  function automatic logic [31:0] gen_inst();
    logic [6:0] opcs[11];
    logic [31:0] i;
    int k;
    opcs = '{LUI, AUIPC, JAL, JALR, BR, LD, ST, OPI, OP, FEN, SYS};
    i = $urandom;
    i[19:15] = 5'($urandom_range(0, 7));
    i[24:20] = 5'($urandom_range(0, 7));
    i[11:7]  = 5'($urandom_range(0, 7));
    k = $urandom_range(0, 12);
    if (k < 11) begin
      i[6:0] = opcs[k];
      if (opcs[k] == OP || opcs[k] == OPI)
        case ($urandom_range(0, 3))
          0, 1: i[31:25] = 7'h00;
          2:    i[31:25] = 7'h20;
          default: ;
        endcase
    end else if (k == 11)
      i[6:0] = 7'h2F;
    else
      i[1:0] = 2'($urandom_range(0, 2));
    return i;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1; flush = 0; in_valid = 0; out_ready = 1; in_pc = 0; in_inst = 0;
    rs1_val = 0; rs2_val = 0; wb_en = 0; wb_addr = 0; wb_data = 0;
    repeat (2) tick();
    n_chk++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    n_chk++;
    if ({out_pc, out_rd, out_rd_we, out_imm, out_rs1_val, out_rs2_val, out_alu_op, out_op1_sel,
         out_op2_sel, out_fu, out_func3, out_illegal} !== '0) begin
      n_fail++; $display("FAIL reset_data: pc %h imm %h rs1 %h fu %0d not all zero", out_pc, out_imm, out_rs1_val, out_fu);
    end
    rst = 0; #1;
    n_chk++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_add();
    in_valid = 1; in_inst = 32'h002081B3; in_pc = 32'h100; rs1_val = 5; rs2_val = 7; #1;
    n_chk++;
    if ({rs1_addr, rs2_addr} !== {5'd1, 5'd2}) begin n_fail++; $display("FAIL add_addr: got %0d %0d want 1 2", rs1_addr, rs2_addr); end
    tick(); in_valid = 0;
    n_chk++;
    if ({out_valid, out_rs1_val, out_rs2_val, out_alu_op, out_rd, out_rd_we} !== {1'b1, 32'd5, 32'd7, 4'd0, 5'd3, 1'b1}) begin
      n_fail++; $display("FAIL add_bundle: v %b rs1 %h rs2 %h alu %0d rd %0d we %b want 1 5 7 0 3 1",
                         out_valid, out_rs1_val, out_rs2_val, out_alu_op, out_rd, out_rd_we);
    end
  endtask

  task automatic test_imm();
    in_valid = 1; in_inst = 32'hFFF00093; in_pc = 32'h104; tick();
    n_chk++;
    if ({out_valid, out_imm, out_op2_sel} !== {1'b1, 32'hFFFFFFFF, 2'd1}) begin
      n_fail++; $display("FAIL addi_imm: imm %h op2 %0d want ffffffff 1", out_imm, out_op2_sel);
    end
    in_inst = 32'hFE000EE3; in_pc = 32'h108; tick(); in_valid = 0;
    n_chk++;
    if ({out_valid, out_imm, out_fu, out_rd_we} !== {1'b1, 32'hFFFFFFFC, 3'd1, 1'b0}) begin
      n_fail++; $display("FAIL beq_imm: imm %h fu %0d we %b want fffffffc 1 0", out_imm, out_fu, out_rd_we);
    end
  endtask

  task automatic test_load_use();
    logic [2:0] v;
    logic [1:0] r;
    in_valid = 0; out_ready = 1; tick();
    in_valid = 1; in_inst = 32'h0000A283; in_pc = 32'h200; tick();
    v[2] = out_valid; in_inst = 32'h00528333; in_pc = 32'h204; #1; r[1] = in_ready;
    tick(); v[1] = out_valid; r[0] = in_ready;
    tick(); v[0] = out_valid; in_valid = 0;
    n_chk++;
    if (v !== 3'b101) begin n_fail++; $display("FAIL lu_valid_seq: got %b want 101", v); end
    n_chk++;
    if (r !== 2'b01) begin n_fail++; $display("FAIL lu_in_ready: got %b want 01", r); end
    n_chk++;
    if ({out_pc, out_rd} !== {32'h204, 5'd6}) begin n_fail++; $display("FAIL lu_dep: pc %h rd %0d want 204 6", out_pc, out_rd); end
  endtask

  task automatic test_backpressure();
    out_ready = 1; in_valid = 1; in_inst = 32'h00100093; in_pc = 32'h300; tick();
    out_ready = 0; in_inst = 32'h002081B3; in_pc = 32'h304;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_chk++;
      if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready c%0d: got %b want 0", c, in_ready); end
      tick();
      n_chk++;
      if ({out_valid, out_pc, out_imm} !== {1'b1, 32'h300, 32'h1}) begin
        n_fail++; $display("FAIL bp_hold c%0d: v %b pc %h imm %h want 1 300 1", c, out_valid, out_pc, out_imm);
      end
    end
    out_ready = 1; #1;
    n_chk++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release: in_ready %b want 1", in_ready); end
    tick(); in_valid = 0;
    n_chk++;
    if ({out_valid, out_pc} !== {1'b1, 32'h304}) begin n_fail++; $display("FAIL bp_next: v %b pc %h want 1 304", out_valid, out_pc); end
  endtask

  task automatic test_bypass();
    in_valid = 1; in_inst = 32'h002081B3; in_pc = 32'h310; rs1_val = 5; rs2_val = 7;
    wb_en = 1; wb_addr = 1; wb_data = 32'hDEADBEEF; tick();
    n_chk++;
    if ({out_rs1_val, out_rs2_val} !== {32'hDEADBEEF, 32'd7}) begin
      n_fail++; $display("FAIL bypass_rs1: rs1 %h rs2 %h want deadbeef 7", out_rs1_val, out_rs2_val);
    end
    in_inst = 32'h002001B3; wb_addr = 0; tick();
    wb_en = 0; in_valid = 0;
    n_chk++;
    if (out_rs1_val !== 32'h0) begin n_fail++; $display("FAIL bypass_x0: rs1 %h want 0", out_rs1_val); end
  endtask

  task automatic test_illegal();
    in_valid = 1; in_inst = 32'h0; in_pc = 32'h320; tick(); in_valid = 0;
    n_chk++;
    if ({out_illegal, out_rd_we, out_fu} !== {1'b1, 1'b0, 3'd5}) begin
      n_fail++; $display("FAIL illegal_zero: ill %b we %b fu %0d want 1 0 5", out_illegal, out_rd_we, out_fu);
    end
  endtask

  task automatic test_flush();
    in_valid = 1; in_inst = 32'h00100093; in_pc = 32'h400; tick();
    flush = 1; in_inst = 32'h002081B3; in_pc = 32'h404; #1;
    n_chk++;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_in_ready: got %b want 0", in_ready); end
    tick();
    n_chk++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid: got %b want 0", out_valid); end
    flush = 0; in_valid = 0; tick();
    n_chk++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_drop: got %b want 0", out_valid); end
  endtask

  task automatic test_reset_mid_stall();
    out_ready = 0; in_valid = 1; in_inst = 32'h0000A283; in_pc = 32'h500; tick();
    in_inst = 32'h00528333; in_pc = 32'h504; #1;
    n_chk++;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_stall_ready: got %b want 0", in_ready); end
    rst = 1; tick();
    n_chk++;
    if ({out_valid, out_pc, out_rd, out_rd_we, out_imm, out_rs1_val, out_rs2_val, out_alu_op,
         out_op1_sel, out_op2_sel, out_fu, out_func3, out_illegal} !== '0) begin
      n_fail++; $display("FAIL rst_stall_out: v %b pc %h fu %0d rd %0d not all zero", out_valid, out_pc, out_fu, out_rd);
    end
    rst = 0; in_valid = 0; out_ready = 1; tick();
  endtask

  task automatic test_random();
    exp_t e, prev;
    bit pv, stall;
    logic [31:0] i;
    pv = 0;
    for (int it = 0; it < 300; it++) begin
      if ($urandom_range(0, 3) == 0) begin in_valid = 0; tick(); pv = 0; end
      i = gen_inst();
      in_inst = i; in_pc = $urandom & 32'hFFFFFFFC; rs1_val = $urandom; rs2_val = $urandom;
      wb_en = 1'($urandom_range(0, 1)); wb_addr = 5'($urandom_range(0, 7)); wb_data = $urandom;
      in_valid = 1;
      e = model(i, in_pc, rs1_val, rs2_val, wb_en, wb_addr, wb_data);
      stall = pv && prev.fu == 3'd3 && prev.rd != 0 &&
              ((e.u1 && i[19:15] == prev.rd) || (e.u2 && i[24:20] == prev.rd));
      #1;
      n_chk++;
      if (in_ready !== !stall) begin n_fail++; $display("FAIL rnd%0d in_ready: got %b want %b inst %h", it, in_ready, !stall, i); end
      if (stall) begin
        tick();
        n_chk++;
        if ({out_valid, in_ready} !== 2'b01) begin
          n_fail++; $display("FAIL rnd%0d bubble: valid %b in_ready %b want 0 1", it, out_valid, in_ready);
        end
      end
      tick();
      n_chk++;
      if ({out_valid, out_pc, out_func3, out_illegal, out_rd_we, out_fu} !== {1'b1, e.pc, e.f3, e.ill, e.rd_we, e.fu}) begin
        n_fail++; $display("FAIL rnd%0d ctl inst %h: v%b pc %h f3 %0d ill %b we %b fu %0d want pc %h f3 %0d ill %b we %b fu %0d",
                           it, i, out_valid, out_pc, out_func3, out_illegal, out_rd_we, out_fu, e.pc, e.f3, e.ill, e.rd_we, e.fu);
      end
      n_chk++;
      if ({out_rs1_val, out_rs2_val} !== {e.r1, e.r2}) begin
        n_fail++; $display("FAIL rnd%0d operands inst %h: %h %h want %h %h", it, i, out_rs1_val, out_rs2_val, e.r1, e.r2);
      end
      if (e.rd_we) begin
        n_chk++;
        if (out_rd !== e.rd) begin n_fail++; $display("FAIL rnd%0d rd inst %h: %0d want %0d", it, i, out_rd, e.rd); end
      end
      if (e.chk_imm) begin
        n_chk++;
        if (out_imm !== e.imm) begin n_fail++; $display("FAIL rnd%0d imm inst %h: %h want %h", it, i, out_imm, e.imm); end
      end
      if (e.chk_alu) begin
        n_chk++;
        if (out_alu_op !== e.alu) begin n_fail++; $display("FAIL rnd%0d alu inst %h: %0d want %0d", it, i, out_alu_op, e.alu); end
      end
      if (e.chk_sel) begin
        n_chk++;
        if ({out_op1_sel, out_op2_sel} !== {e.op1, e.op2}) begin
          n_fail++; $display("FAIL rnd%0d sel inst %h: %0d %0d want %0d %0d", it, i, out_op1_sel, out_op2_sel, e.op1, e.op2);
        end
      end
      prev = e; pv = 1;
    end
    in_valid = 0; wb_en = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_add();
    test_imm();
    test_load_use();
    test_backpressure();
    test_bypass();
    test_illegal();
    test_flush();
    test_reset_mid_stall();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Registered, handshaked RV32I/RV32E instruction decode stage between fetch and execute.
- Decodes the full base opcode map into ALU, operand-select and functional-unit controls, and generates immediates.
- Reads register operands, with optional write-back bypass, and enforces a one-bubble load-use interlock.
- Supports a pipeline flush and flags illegal instructions.

Parameters:
- XLEN, 32: data/PC width; only 32 is legal.
- RF_ADDR_W, 5: register index width; 5 = RV32I, 4 = RV32E.
- BYPASS_EN, 1: forward the write-back value onto operand reads.
- HAZARD_EN, 1: enable the load-use interlock.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- flush  in  1  discard held and incoming instruction
- in_valid  in  1  fetch holds an instruction
- in_ready  out  1  decode accepts this cycle
- in_pc  in  XLEN  instruction PC
- in_inst  in  32  instruction word
- rs1_addr  out  RF_ADDR_W  regfile read address 1, from in_inst[19:15]
- rs2_addr  out  RF_ADDR_W  regfile read address 2, from in_inst[24:20]
- rs1_val  in  XLEN  combinational regfile data 1
- rs2_val  in  XLEN  combinational regfile data 2
- wb_en  in  1  write-back valid
- wb_addr  in  RF_ADDR_W  write-back index
- wb_data  in  XLEN  write-back data
- out_valid  out  1  decoded bundle valid
- out_ready  in  1  execute accepts
- out_pc  out  XLEN  PC
- out_rd  out  RF_ADDR_W  destination index
- out_rd_we  out  1  destination write enable
- out_imm  out  XLEN  sign-extended immediate
- out_rs1_val  out  XLEN  operand 1 register value
- out_rs2_val  out  XLEN  operand 2 register value
- out_alu_op  out  4  ALU operation code
- out_op1_sel  out  2  operand 1 source select
- out_op2_sel  out  2  operand 2 source select
- out_fu  out  3  functional-unit class
- out_func3  out  3  funct3 passthrough
- out_illegal  out  1  illegal instruction flag

Behaviour:

Clock and reset:
- One clock; reset is synchronous and active-high.
- While rst=1: out_valid=0 and every data output =0. The held bundle is discarded, including mid-handshake.

Handshake and latency:
- Latency is 1 cycle: an accept in cycle N presents its bundle in cycle N+1.
- in_ready = (!out_valid || out_ready) && !stall_lu && !flush.
- Accept occurs when in_valid && in_ready.
- Output register update priority:
  1. flush: out_valid<=0. Same-cycle input is dropped.
  2. Accept: load the new bundle, out_valid<=1.
  3. out_ready && !stall_lu-accept: out_valid<=0.
  4. Otherwise: hold.
- While out_valid && !out_ready, all outputs are stable.

Load-use interlock (HAZARD_EN=1):
- stall_lu is asserted when all of the following hold:
  - out_valid is set;
  - out_fu=LOAD;
  - out_rd≠0;
  - in_valid is set;
  - the incoming instruction uses rs1 or rs2 and that index equals out_rd.
- Effect: the load leaves on out_ready, and the output goes invalid for one cycle (a bubble). The dependent instruction is accepted the next cycle.
- "Uses rs1": all formats except LUI, AUIPC, JAL.
- "Uses rs2": OP, STORE, BRANCH.

Operand read:
- Index 0 reads as 0.
- If BYPASS_EN && wb_en && wb_addr==index && index≠0, the operand takes wb_data; otherwise it takes rs*_val.

Encodings:
- alu_op: ADD0 SUB1 SLL2 SLT3 SLTU4 XOR5 SRL6 SRA7 OR8 AND9 PASSB10.
- op1_sel: RS1=0 PC=1 ZERO=2.
- op2_sel: RS2=0 IMM=1 FOUR=2.
- fu: ALU0 BRANCH1 JUMP2 LOAD3 STORE4 SYSTEM5.

Decode per opcode:
- LUI: ZERO+IMM, PASSB, fu=ALU.
- AUIPC: PC+IMM, ADD, fu=ALU.
- JAL/JALR: PC+FOUR, ADD, fu=JUMP; the target is computed from imm.
- BRANCH: RS1,RS2, SUB, rd_we=0, fu=BRANCH.
- LOAD: RS1+IMM, fu=LOAD.
- STORE: RS1+IMM, rd_we=0, fu=STORE.
- OP-IMM: RS1,IMM (or SHAMT zero-extended in imm for SLLI/SRLI/SRAI).
- OP: RS1,RS2.
- FENCE: fu=SYSTEM, no write.
- SYSTEM: fu=SYSTEM, no write.
- rd_we=1 only for LUI, AUIPC, JAL, JALR, LOAD, OP-IMM and OP, and only when rd≠0.

Immediates (all sign-extended from inst[31]):
- U: {inst[31:12],12'b0}.
- I: inst[31:20].
- S: {inst[31:25],inst[11:7]}.
- B: {inst[31],inst[7],inst[30:25],inst[11:8],0}.
- J: {inst[31],inst[19:12],inst[20],inst[30:21],0}.

Illegal conditions:
- inst[1:0]≠11.
- Unknown opcode.
- OP funct7∉{0,0x20}, or funct7=0x20 with funct3∉{000,101}.
- Shift-immediate funct7 fails the same rule.
- BRANCH funct3 010/011.
- LOAD funct3 011/110/111.
- STORE funct3≥011.
- JALR funct3≠0.
- RV32E: any used register index ≥16.

Illegal handling:
- out_illegal=1, rd_we=0, fu=SYSTEM.
- The instruction is still passed downstream; the trap is taken later.

Test Plan:
- ADD 0x002081B3, rs1_val=5, rs2_val=7 -> next cycle: out_valid=1, rs1 5, rs2 7, alu_op=0, rd=3, rd_we=1.
- ADDI 0xFFF00093 -> imm 0xFFFFFFFF, op2_sel=1. BEQ 0xFE000EE3 -> imm 0xFFFFFFFC, fu=1, rd_we=0.
- LW 0x0000A283 then ADD 0x00528333, out_ready=1 -> out_valid sequence 1,0,1; in_ready=0 for exactly one cycle.
- out_ready=0 for 3 cycles with in_valid=1 -> outputs frozen, in_ready=0; then out_ready=1 -> next bundle one cycle later.
- wb_en=1, wb_addr=1, wb_data=0xDEADBEEF with ADD accepted and rs1_val=5 -> out_rs1_val=0xDEADBEEF. Same with wb_addr=0 -> value 0.
- 0x00000000 -> out_illegal=1. flush with out_valid=1 and in_valid=1 -> next cycle out_valid=0 and the input is dropped. rst mid-stall -> all outputs 0.
